pipeline_ctrl: RTL

Central pipeline control for the 5-stage MIPS core. It produces the EN/flush pair consumed by each pipe register (IF_ID, ID_EX, EX_MEM, MEM_WB) and the PC enable. It is the driving end of the EN/flush protocol: it detects load-use hazards, branch/jump redirects, instruction/data memory waits and halt drain. A small FSM sequences memory waits and the halt drain; optional counters record stall and flush cycles.

---
 rtl/pipeline_ctrl.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
// Central pipeline control for the 5-stage MIPS core. Produces the EN/flush
// pair for each pipe register (IF_ID, ID_EX, EX_MEM, MEM_WB) plus the PC
// enable. Detects load-use hazards, EX redirects (branch taken / jump),
// instruction and data memory waits, and sequences the halt drain.
//
// Optional feature macro: PIPE_PERF_EN
//   defined   -> saturating stall/flush cycle counters are built
//   undefined -> stall_cnt / flush_cnt are constant 0
//
// Ports:
//   CLK, RST            clock (rising edge), async active-high reset
//   ihit, dhit          fetch / data access complete this cycle
//   id_rs, id_rt,
//   id_uses_rt          source registers of the instruction in IF_ID
//   ex_dREN, ex_wsel    load in EX and its destination register
//   ex_redirect         branch taken or jump resolved in EX
//   ex_halt             halt instruction in EX
//   mem_dREN, mem_dWEN  data access in MEM
//   wb_halt             halt instruction in WB
//   pc_EN               PC update enable
//   {fd,dx,xm,mw}_EN    pipe register advance enables
//   {fd,dx,xm,mw}_flush pipe register flushes (flush wins over EN)
//   halt                sticky core halt (registered)
//   stall_cnt           cycles with pc_EN=0 while not HALTED
//   flush_cnt           cycles with fd_flush or dx_flush asserted
//   state_dbg           current FSM state (RUN=0, DWAIT=1, DRAIN=2, HALTED=3)
//
// Handshake: each pipe register advances when its EN=1 and flush=0, clears
// to a bubble when flush=1, and holds otherwise. pc_EN=1 lets the PC update.
// -----------------------------------------------------------------------------
module pipeline_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_dREN,
    input  logic [4:0]       ex_wsel,
    input  logic             ex_redirect,
    input  logic             ex_halt,
    input  logic             mem_dREN,
    input  logic             mem_dWEN,
    input  logic             wb_halt,
    output logic             pc_EN,
    output logic             fd_EN,
    output logic             fd_flush,
    output logic             dx_EN,
    output logic             dx_flush,
    output logic             xm_EN,
    output logic             xm_flush,
    output logic             mw_EN,
    output logic             mw_flush,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   ret_drain;      // DWAIT returns to DRAIN (1) or RUN (0)
    logic   ret_drain_nxt;
    logic   halt_q;

    logic dmem_busy;
    logic load_use;
    logic eval_rules;
    logic drain_mode;

    assign dmem_busy = (mem_dREN | mem_dWEN) & ~dhit;
    assign load_use  = ex_dREN & (ex_wsel != 5'd0) &
                       ((ex_wsel == id_rs) | (id_uses_rt & (ex_wsel == id_rt)));

    assign state_dbg = state;
    assign halt      = halt_q;

    // Pipe control outputs: combinational from inputs and registered state.
    always_comb begin
        pc_EN      = 1'b0;
        fd_EN      = 1'b0;
        fd_flush   = 1'b0;
        dx_EN      = 1'b0;
        dx_flush   = 1'b0;
        xm_EN      = 1'b0;
        xm_flush   = 1'b0;
        mw_EN      = 1'b0;
        mw_flush   = 1'b0;
        eval_rules = 1'b0;
        drain_mode = 1'b0;

        if (!RST) begin
            case (state)
                RUN:     begin eval_rules = 1'b1; drain_mode = 1'b0;      end
                DRAIN:   begin eval_rules = 1'b1; drain_mode = 1'b1;      end
                // While busy the rules below freeze everything; on the dhit
                // cycle the return state's rules apply directly.
                DWAIT:   begin eval_rules = 1'b1; drain_mode = ret_drain; end
                default: begin eval_rules = 1'b0; drain_mode = 1'b0;      end
            endcase
        end

        if (eval_rules && !dmem_busy) begin
            if (ex_redirect) begin
                // Redirect beats load-use and an ifetch stall: the wrong-path
                // instructions in IF_ID and ID_EX are discarded anyway.
                pc_EN    = 1'b1;
                fd_EN    = 1'b1;
                fd_flush = 1'b1;
                dx_EN    = 1'b1;
                dx_flush = 1'b1;
                xm_EN    = 1'b1;
                mw_EN    = 1'b1;
            end else if (load_use) begin
                // Hold PC and IF_ID, insert a bubble into ID_EX.
                dx_EN    = 1'b1;
                dx_flush = 1'b1;
                xm_EN    = 1'b1;
                mw_EN    = 1'b1;
            end else if (!ihit) begin
                // Fetch not done: bubble into IF_ID, older stages advance.
                fd_EN    = 1'b1;
                fd_flush = 1'b1;
                dx_EN    = 1'b1;
                xm_EN    = 1'b1;
                mw_EN    = 1'b1;
            end else begin
                pc_EN    = 1'b1;
                fd_EN    = 1'b1;
                dx_EN    = 1'b1;
                xm_EN    = 1'b1;
                mw_EN    = 1'b1;
            end

            // Draining: nothing new is fetched past the halt.
            if (drain_mode) begin
                pc_EN    = 1'b0;
                fd_flush = 1'b1;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt     = state;
        ret_drain_nxt = ret_drain;
        case (state)
            RUN: begin
                if (dmem_busy) begin
                    state_nxt     = DWAIT;
                    ret_drain_nxt = 1'b0;
                end else if (ex_halt) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (dmem_busy) begin
                    state_nxt     = DWAIT;
                    ret_drain_nxt = 1'b1;
                end
            end
            DWAIT: begin
                if (!dmem_busy) begin
                    // The dhit cycle behaves as the return state, so a halt
                    // sitting in EX on that cycle still starts the drain.
                    if (ret_drain || ex_halt) begin
                        state_nxt = DRAIN;
                    end else begin
                        state_nxt = RUN;
                    end
                end
            end
            default: state_nxt = HALTED;
        endcase

        if (wb_halt && (state != HALTED)) begin
            state_nxt = HALTED;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= RUN;
            ret_drain <= 1'b0;
            halt_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            ret_drain <= ret_drain_nxt;
            halt_q    <= (state_nxt == HALTED);
        end
    end

`ifdef PIPE_PERF_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;
    logic             stall_inc;
    logic             flush_inc;

    // Counting stops once HALTED so the values survive for inspection.
    assign stall_inc = ~pc_EN & (state != HALTED);
    assign flush_inc = (fd_flush | dx_flush) & (state != HALTED);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall_inc && (stall_q != {CNT_W{1'b1}})) begin
                stall_q <= stall_q + 1'b1;
            end
            if (flush_inc && (flush_q != {CNT_W{1'b1}})) begin
                flush_q <= flush_q + 1'b1;
            end
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
